draw_sched: RTL and testbench

Two-requester rectangle-fill scheduler for the VGA pixel-write path.
- Arbitrates round-robin between requesters A and B; each request is a rectangle job.
- Normalises and clips the granted rectangle, then streams one coordinate per cycle, row-major, into the 3-stage coordinate/done alignment pipeline ahead of the frame buffer.
- Acknowledges the job only after its last pixel has drained out of that pipeline, so the next job cannot overlap it.

---
 rtl/draw_pkg.sv | 24 ++
 rtl/rect_scan.sv | 81 ++++++++
 rtl/draw_sched.sv | 159 +++++++++++++++
 tb/tb_draw_sched.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// +----------------------------------------------------------------------+
// | draw_pkg : shared types and constants for the rectangle-fill path    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package draw_pkg;

  localparam int COORD_W     = 11;
  localparam int HRES        = 640;
  localparam int VRES        = 480;
  localparam int DRAIN_DEPTH = 3;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rect_scan.sv
// +----------------------------------------------------------------------+
// | rect_scan : row-major cx/cy walker over a latched rectangle          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rect_scan #(
  parameter int W = draw_pkg::COORD_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] xl_in,
  input  logic [W-1:0] xh_in,
  input  logic [W-1:0] yl_in,
  input  logic [W-1:0] yh_in,
  output logic [W-1:0] cx,
  output logic [W-1:0] cy,
  output logic         last,
  output logic         last_nxt
);

  logic [W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [W-1:0] xl_q, xl_d, xh_q, xh_d, yl_q, yl_d, yh_q, yh_d;
  logic         last_q, last_d;

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    xl_d = xl_q;
    xh_d = xh_q;
    yl_d = yl_q;
    yh_d = yh_q;
    if (load) begin
      xl_d = xl_in;
      xh_d = xh_in;
      yl_d = yl_in;
      yh_d = yh_in;
      cx_d = xl_in;
      cy_d = yl_in;
    end else if (step) begin
      if (cx_q == xh_q) begin
        cx_d = xl_q;
        cy_d = cy_q + W'(1);
      end else begin
        cx_d = cx_q + W'(1);
      end
    end
    // Look-ahead so the owner can register done_pre alongside the pixel.
    last_d = (cx_d == xh_d) && (cy_d == yh_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cx_q   <= '0;
      cy_q   <= '0;
      xl_q   <= '0;
      xh_q   <= '0;
      yl_q   <= '0;
      yh_q   <= '0;
      last_q <= 1'b0;
    end else begin
      cx_q   <= cx_d;
      cy_q   <= cy_d;
      xl_q   <= xl_d;
      xh_q   <= xh_d;
      yl_q   <= yl_d;
      yh_q   <= yh_d;
      last_q <= last_d;
    end
  end

  assign cx       = cx_q;
  assign cy       = cy_q;
  assign last     = last_q;
  assign last_nxt = last_d;

endmodule

`default_nettype wire

// File: rtl/draw_sched.sv
// +----------------------------------------------------------------------+
// | draw_sched : two-requester round-robin rectangle-fill scheduler      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module draw_sched #(
  parameter int W     = draw_pkg::COORD_W,
  parameter int HRES  = draw_pkg::HRES,
  parameter int VRES  = draw_pkg::VRES,
  parameter int DRAIN = draw_pkg::DRAIN_DEPTH
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_a,
  input  logic         req_b,
  input  logic [W-1:0] a_x0,
  input  logic [W-1:0] a_y0,
  input  logic [W-1:0] a_x1,
  input  logic [W-1:0] a_y1,
  input  logic [W-1:0] b_x0,
  input  logic [W-1:0] b_y0,
  input  logic [W-1:0] b_x1,
  input  logic [W-1:0] b_y1,
  output logic         ack_a,
  output logic         ack_b,
  output logic [W-1:0] x_pre,
  output logic [W-1:0] y_pre,
  output logic         valid_pre,
  output logic         done_pre,
  output logic         busy,
  output logic         grant_b
);

  import draw_pkg::*;

  localparam int           CW    = $clog2(DRAIN + 1);
  localparam logic [W-1:0] X_MAX = W'(HRES - 1);
  localparam logic [W-1:0] Y_MAX = W'(VRES - 1);

  function automatic logic [W-1:0] clip(input logic [W-1:0] v, input logic [W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ptr_q, ptr_d;          // 1 = B was granted last
  logic          grant_b_q, grant_b_d;
  logic          ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic          valid_q, valid_d, done_q, done_d, busy_q, busy_d;

  logic          pick_b;
  logic [W-1:0]  sx0, sx1, sy0, sy1;
  logic [W-1:0]  nxl, nxh, nyl, nyh;
  logic          scan_load, scan_step, scan_last, scan_last_nxt;

  assign pick_b = req_b & (~req_a | ~ptr_q);

  always_comb begin
    sx0 = pick_b ? b_x0 : a_x0;
    sx1 = pick_b ? b_x1 : a_x1;
    sy0 = pick_b ? b_y0 : a_y0;
    sy1 = pick_b ? b_y1 : a_y1;
    nxl = clip((sx0 < sx1) ? sx0 : sx1, X_MAX);
    nxh = clip((sx0 < sx1) ? sx1 : sx0, X_MAX);
    nyl = clip((sy0 < sy1) ? sy0 : sy1, Y_MAX);
    nyh = clip((sy0 < sy1) ? sy1 : sy0, Y_MAX);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    grant_b_d = grant_b_q;
    scan_load = 1'b0;
    scan_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_a || req_b) begin
          grant_b_d = pick_b;
          ptr_d     = pick_b;
          scan_load = 1'b1;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (scan_last) begin
          cnt_d   = CW'(DRAIN);
          state_d = ST_DRAIN;
        end else begin
          scan_step = 1'b1;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // All outputs are flopped, so decode them from the next-state view.
    valid_d = (state_d == ST_SCAN);
    done_d  = (state_d == ST_SCAN) && scan_last_nxt;
    busy_d  = (state_d != ST_IDLE);
    ack_a_d = (state_d == ST_DRAIN) && (cnt_d == CW'(1)) && !grant_b_d;
    ack_b_d = (state_d == ST_DRAIN) && (cnt_d == CW'(1)) &&  grant_b_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= 1'b1;
      grant_b_q <= 1'b0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      grant_b_q <= grant_b_d;
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  rect_scan #(.W(W)) u_scan (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (scan_load),
    .step     (scan_step),
    .xl_in    (nxl),
    .xh_in    (nxh),
    .yl_in    (nyl),
    .yh_in    (nyh),
    .cx       (x_pre),
    .cy       (y_pre),
    .last     (scan_last),
    .last_nxt (scan_last_nxt)
  );

  assign ack_a     = ack_a_q;
  assign ack_b     = ack_b_q;
  assign valid_pre = valid_q;
  assign done_pre  = done_q;
  assign busy      = busy_q;
  assign grant_b   = grant_b_q;

endmodule

`default_nettype wire

// File: tb/tb_draw_sched.sv
// +----------------------------------------------------------------------+
// | tb_draw_sched : directed self-checking bench for draw_sched          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_draw_sched;

  localparam int W     = 11;
  localparam int DRAIN = 3;

  logic         clk;
  logic         reset_n;
  logic         req_a, req_b;
  logic [W-1:0] a_x0, a_y0, a_x1, a_y1, b_x0, b_y0, b_x1, b_y1;
  logic         ack_a, ack_b, valid_pre, done_pre, busy, grant_b;
  logic [W-1:0] x_pre, y_pre;

  int n_cmp = 0;
  int n_bad = 0;

  draw_sched #(.W(W), .HRES(640), .VRES(480), .DRAIN(DRAIN)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_a     (req_a),
    .req_b     (req_b),
    .a_x0      (a_x0),
    .a_y0      (a_y0),
    .a_x1      (a_x1),
    .a_y1      (a_y1),
    .b_x0      (b_x0),
    .b_y0      (b_y0),
    .b_x1      (b_x1),
    .b_y1      (b_y1),
    .ack_a     (ack_a),
    .ack_b     (ack_b),
    .x_pre     (x_pre),
    .y_pre     (y_pre),
    .valid_pre (valid_pre),
    .done_pre  (done_pre),
    .busy      (busy),
    .grant_b   (grant_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string ctx);
    check({ctx, "_ack_a"},   ack_a,     0);
    check({ctx, "_ack_b"},   ack_b,     0);
    check({ctx, "_x"},       x_pre,     0);
    check({ctx, "_y"},       y_pre,     0);
    check({ctx, "_valid"},   valid_pre, 0);
    check({ctx, "_done"},    done_pre,  0);
    check({ctx, "_busy"},    busy,      0);
    check({ctx, "_grant_b"}, grant_b,   0);
  endtask

  // Entered in the first-pixel cycle; leaves in the cycle after ack.
  task automatic run_job(input string ctx, input logic exp_b, input int xl, input int xh,
                         input int yl, input int yh, input logic drop);
    for (int y = yl; y <= yh; y++) begin
      for (int x = xl; x <= xh; x++) begin
        check({ctx, "_busy"},    busy,      1);
        check({ctx, "_grant_b"}, grant_b,   exp_b);
        check({ctx, "_valid"},   valid_pre, 1);
        check({ctx, "_x"},       x_pre,     x);
        check({ctx, "_y"},       y_pre,     y);
        check({ctx, "_done"},    done_pre,  (x == xh) && (y == yh));
        check({ctx, "_ack_scan"}, {ack_a, ack_b}, 0);
        tick();
      end
    end
    for (int d = 1; d <= DRAIN; d++) begin
      check({ctx, "_drain_busy"},  busy,      1);
      check({ctx, "_drain_valid"}, valid_pre, 0);
      check({ctx, "_drain_done"},  done_pre,  0);
      check({ctx, "_drain_x"},     x_pre,     xh);
      check({ctx, "_drain_y"},     y_pre,     yh);
      check({ctx, "_ack_a"},       ack_a,     (d == DRAIN) && !exp_b);
      check({ctx, "_ack_b"},       ack_b,     (d == DRAIN) &&  exp_b);
      if (d == DRAIN && drop) begin
        if (exp_b) req_b = 1'b0;
        else       req_a = 1'b0;
      end
      tick();
    end
    check({ctx, "_post_busy"}, busy, 0);
    check({ctx, "_post_ack"},  {ack_a, ack_b}, 0);
  endtask

  task automatic set_a(input int x0, input int y0, input int x1, input int y1);
    a_x0 = W'(x0); a_y0 = W'(y0); a_x1 = W'(x1); a_y1 = W'(y1);
  endtask

  task automatic set_b(input int x0, input int y0, input int x1, input int y1);
    b_x0 = W'(x0); b_y0 = W'(y0); b_x1 = W'(x1); b_y1 = W'(y1);
  endtask

  initial begin
    reset_n = 1'b0;
    req_a   = 1'b0;
    req_b   = 1'b0;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    repeat (2) tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();
    check_all_zero("idle");

    // Single job with grant latency of one cycle.
    set_a(2, 3, 4, 4);
    req_a = 1'b1;
    tick();
    run_job("single", 1'b0, 2, 4, 3, 4, 1'b1);

    // Tie after reset goes to A; A re-requests, B is served next, then A again.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    set_a(1, 0, 0, 0);
    set_b(700, 500, 638, 478);
    req_a = 1'b1;
    req_b = 1'b1;
    tick();
    run_job("tie_a", 1'b0, 0, 1, 0, 0, 1'b0);
    set_a(5, 5, 5, 5);
    tick();
    run_job("clip_b", 1'b1, 638, 639, 478, 479, 1'b1);
    tick();
    run_job("pix1", 1'b0, 5, 5, 5, 5, 1'b1);

    // Reset during the third pixel of a 4x4 job aborts it.
    set_a(0, 0, 3, 3);
    req_a = 1'b1;
    tick();
    tick();
    tick();
    check("mid_x", x_pre, 2);
    check("mid_valid", valid_pre, 1);
    reset_n = 1'b0;
    #1;
    check_all_zero("abort");
    set_a(2, 1, 1, 1);
    set_b(9, 9, 9, 9);
    req_b = 1'b1;
    tick();
    check_all_zero("abort_hold");
    reset_n = 1'b1;
    tick();
    run_job("post_rst_a", 1'b0, 1, 2, 1, 1, 1'b1);
    tick();
    run_job("post_rst_b", 1'b1, 9, 9, 9, 9, 1'b1);

    // B rising mid-scan waits for A's ack.
    set_a(2, 0, 0, 0);
    req_a = 1'b1;
    tick();
    set_b(7, 8, 7, 8);
    req_b = 1'b1;
    run_job("late_a", 1'b0, 0, 2, 0, 0, 1'b1);
    tick();
    run_job("late_b", 1'b1, 7, 7, 8, 8, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
